// File: rtl/alu_shift_sequencer.sv
// Multi-cycle operand/opcode sequencer for the 32-bit ALU: single-pass ops and N-bit shifts/rotates.
// Optional Abort input is enabled by defining ALU_SEQ_ABORT_EN.
module alu_shift_sequencer #(
   parameter int WIDTH = 32,
   parameter int AMT_W = 5
) (
   input  logic             Clk,
   input  logic             Reset_n,
`ifdef ALU_SEQ_ABORT_EN
   input  logic             Abort,
`endif
   input  logic             Start,
   input  logic [3:0]       Op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [AMT_W-1:0] Amt,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] Result,
   output logic             Zero,
   output logic             Err,
   output logic [WIDTH-1:0] Alu_A,
   output logic [WIDTH-1:0] Alu_B,
   output logic [3:0]       Alu_Op,
   input  logic [WIDTH-1:0] Alu_Out,
   input  logic             Alu_Zero
);

   typedef enum logic {IDLE, EXEC} state_t;

   state_t             r_state;
   state_t             w_next_state;
   logic [WIDTH-1:0]   r_acc;
   logic [WIDTH-1:0]   r_breg;
   logic [3:0]         r_opreg;
   logic [AMT_W-1:0]   r_cnt;
   logic [WIDTH-1:0]   r_result;
   logic               r_busy;
   logic               r_done;
   logic               r_zero;
   logic               r_err;

   logic               w_single;
   logic               w_iter;
   logic               w_abort;
   logic               w_load;
   logic               w_finish;
   logic               w_zero_pass;
   logic               w_invalid;

`ifdef ALU_SEQ_ABORT_EN
   assign w_abort = Abort;
`else
   assign w_abort = 1'b0;
`endif

   always_comb begin
      w_single = 1'b0;
      w_iter   = 1'b0;
      case (Op)
         4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100: w_single = 1'b1;
         4'b1000, 4'b1001, 4'b1010, 4'b1100, 4'b1101: w_iter   = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) r_state <= IDLE;
      else          r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      w_load       = 1'b0;
      w_finish     = 1'b0;
      w_zero_pass  = 1'b0;
      w_invalid    = 1'b0;
      case (r_state)
         IDLE: begin
            if (Start) begin
               if (w_single || (w_iter && (Amt != '0))) begin
                  w_next_state = EXEC;
                  w_load       = 1'b1;
               end else if (w_iter) begin
                  w_zero_pass  = 1'b1;
               end else begin
                  w_invalid    = 1'b1;
               end
            end
         end
         EXEC: begin
            // Abort wins over a completion landing on the same edge.
            if (w_abort) begin
               w_next_state = IDLE;
            end else if (r_cnt == AMT_W'(1)) begin
               w_next_state = IDLE;
               w_finish     = 1'b1;
            end
         end
         default: w_next_state = IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_acc    <= '0;
         r_breg   <= '0;
         r_opreg  <= '0;
         r_cnt    <= '0;
         r_result <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_zero   <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_busy <= (w_next_state == EXEC);
         r_done <= w_finish | w_zero_pass | w_invalid;

         if (w_load) begin
            r_acc   <= A;
            r_breg  <= B;
            r_opreg <= Op;
            r_cnt   <= w_single ? AMT_W'(1) : Amt;
         end else if (r_state == EXEC) begin
            r_acc <= Alu_Out;
            r_cnt <= r_cnt - AMT_W'(1);
         end

         if (w_finish) begin
            r_result <= Alu_Out;
            r_zero   <= Alu_Zero;
            r_err    <= 1'b0;
         end else if (w_zero_pass) begin
            r_result <= A;
            r_zero   <= (A == '0);
            r_err    <= 1'b0;
         end else if (w_invalid) begin
            r_result <= '0;
            r_zero   <= 1'b1;
            r_err    <= 1'b1;
         end
      end
   end

   assign Busy   = r_busy;
   assign Done   = r_done;
   assign Result = r_result;
   assign Zero   = r_zero;
   assign Err    = r_err;
   assign Alu_A  = r_acc;
   assign Alu_B  = r_breg;
   assign Alu_Op = r_opreg;

endmodule

// File: tb/tb_alu_shift_sequencer.sv
// Directed bench for alu_shift_sequencer with a behavioural 1-bit-shift ALU on the Alu_* ports.
// Exercises the Abort path instead of mid-op reset when ALU_SEQ_ABORT_EN is defined.
module tb_alu_shift_sequencer;

   logic        Clk = 1'b0;
   logic        Reset_n = 1'b0;
   logic        Start = 1'b0;
   logic [3:0]  Op = '0;
   logic [31:0] A = '0;
   logic [31:0] B = '0;
   logic [4:0]  Amt = '0;
   logic        Busy, Done, Zero, Err, Alu_Zero;
   logic [31:0] Result, Alu_A, Alu_B, Alu_Out;
   logic [3:0]  Alu_Op;
`ifdef ALU_SEQ_ABORT_EN
   logic        Abort = 1'b0;
`endif

   int checks = 0;
   int errors = 0;

   always #5 Clk = ~Clk;

   alu_shift_sequencer #(.WIDTH(32), .AMT_W(5)) dut (
      .Clk(Clk), .Reset_n(Reset_n),
`ifdef ALU_SEQ_ABORT_EN
      .Abort(Abort),
`endif
      .Start(Start), .Op(Op), .A(A), .B(B), .Amt(Amt),
      .Busy(Busy), .Done(Done), .Result(Result), .Zero(Zero), .Err(Err),
      .Alu_A(Alu_A), .Alu_B(Alu_B), .Alu_Op(Alu_Op),
      .Alu_Out(Alu_Out), .Alu_Zero(Alu_Zero)
   );

   // ALU stand-in: shifts and rotates move one bit per pass
   always_comb begin
      case (Alu_Op)
         4'b0000: Alu_Out = Alu_A + Alu_B;
         4'b0001: Alu_Out = Alu_A - Alu_B;
         4'b0010: Alu_Out = Alu_A & Alu_B;
         4'b0011: Alu_Out = Alu_A | Alu_B;
         4'b0100: Alu_Out = ~Alu_A;
         4'b1000: Alu_Out = {Alu_A[31], Alu_A[31:1]};
         4'b1001: Alu_Out = {Alu_A[30:0], 1'b0};
         4'b1010: Alu_Out = {1'b0, Alu_A[31:1]};
         4'b1100: Alu_Out = {Alu_A[30:0], Alu_A[31]};
         4'b1101: Alu_Out = {Alu_A[0], Alu_A[31:1]};
         default: Alu_Out = '0;
      endcase
      Alu_Zero = (Alu_Out == '0);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  amt;
      logic [31:0] res;
      int          busy;
      logic        err;
   } vec_t;

   vec_t vecs[$] = '{
      '{4'b0000, 32'd5,          32'd7,          5'd0,  32'd12,         1,  1'b0},
      '{4'b0001, 32'h0000_1234,  32'h0000_1234,  5'd0,  32'h0000_0000,  1,  1'b0},
      '{4'b0010, 32'hF0F0_F0F0,  32'h0FF0_0FF0,  5'd9,  32'h00F0_00F0,  1,  1'b0},
      '{4'b0011, 32'h0000_FFFF,  32'hFFFF_0000,  5'd0,  32'hFFFF_FFFF,  1,  1'b0},
      '{4'b0100, 32'h1234_5678,  32'h0,          5'd0,  32'hEDCB_A987,  1,  1'b0},
      '{4'b1000, 32'h8000_0000,  32'h0,          5'd4,  32'hF800_0000,  4,  1'b0},
      '{4'b1001, 32'h0000_0001,  32'h0,          5'd31, 32'h8000_0000,  31, 1'b0},
      '{4'b1010, 32'hFFFF_FFFF,  32'h0,          5'd8,  32'h00FF_FFFF,  8,  1'b0},
      '{4'b1101, 32'h0000_0001,  32'h0,          5'd1,  32'h8000_0000,  1,  1'b0},
      '{4'b1100, 32'h8000_0001,  32'h0,          5'd31, 32'hC000_0000,  31, 1'b0},
      '{4'b1001, 32'h0000_0000,  32'h0,          5'd0,  32'h0000_0000,  0,  1'b0},
      '{4'b1101, 32'hDEAD_BEEF,  32'h0,          5'd0,  32'hDEAD_BEEF,  0,  1'b0},
      '{4'b0110, 32'h1111_1111,  32'h2,          5'd3,  32'h0000_0000,  0,  1'b1},
      '{4'b1111, 32'h5555_5555,  32'h0,          5'd0,  32'h0000_0000,  0,  1'b1},
      '{4'b0000, 32'h10,         32'h20,         5'd0,  32'h30,         1,  1'b0}
   };

   // Caller sits at a negedge; a stray Start is pulsed mid-run when poke is set.
   task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] amt, input bit poke,
                         output int busy_n, output bit done_seen);
      Start = 1'b1; Op = op; A = a; B = b; Amt = amt;
      @(posedge Clk); #1;
      Start = 1'b0;
      busy_n = 0;
      done_seen = 1'b0;
      for (int c = 0; c < 64; c++) begin
         @(negedge Clk);
         check("busy_done_excl", {31'd0, Busy & Done}, 32'd0);
         if (Done) begin
            done_seen = 1'b1;
            break;
         end
         if (Busy) busy_n++;
         if (poke && busy_n == 2) begin
            Start = 1'b1; Op = 4'b0000; A = 32'hAAAA_0000; B = 32'd1;
         end else begin
            Start = 1'b0;
         end
      end
      Start = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int  busy_n;
      bit  done_seen;
      string tag;

      #12;
      check("rst_busy",   {31'd0, Busy},   32'd0);
      check("rst_done",   {31'd0, Done},   32'd0);
      check("rst_result", Result,          32'd0);
      check("rst_zero",   {31'd0, Zero},   32'd0);
      check("rst_err",    {31'd0, Err},    32'd0);
      check("rst_alu_a",  Alu_A,           32'd0);
      check("rst_alu_op", {28'd0, Alu_Op}, 32'd0);
      Reset_n = 1'b1;
      @(negedge Clk);

      foreach (vecs[i]) begin
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].amt, vecs[i].busy >= 3, busy_n, done_seen);
         tag = $sformatf("v%0d", i);
         check({tag, "_done"},   {31'd0, done_seen},     32'd1);
         check({tag, "_busy"},   busy_n,                 vecs[i].busy);
         check({tag, "_result"}, Result,                 vecs[i].res);
         check({tag, "_zero"},   {31'd0, Zero},          {31'd0, vecs[i].res == 32'd0});
         check({tag, "_err"},    {31'd0, Err},           {31'd0, vecs[i].err});
      end

      // Interrupt a long lsr after three EXEC cycles; Result is 0x30 beforehand.
      Start = 1'b1; Op = 4'b1010; A = 32'hFFFF_FFFF; B = '0; Amt = 5'd8;
      @(posedge Clk); #1;
      Start = 1'b0;
      busy_n = 0;
      for (int c = 0; c < 20 && busy_n < 3; c++) begin
         @(negedge Clk);
         if (Busy) busy_n++;
      end
      check("int_busy_cnt", busy_n, 3);
`ifdef ALU_SEQ_ABORT_EN
      Abort = 1'b1;
      @(negedge Clk);
      Abort = 1'b0;
      check("abort_busy",   {31'd0, Busy}, 32'd0);
      check("abort_done",   {31'd0, Done}, 32'd0);
      check("abort_result", Result,        32'h30);
      check("abort_zero",   {31'd0, Zero}, 32'd0);
      for (int c = 0; c < 8; c++) begin
         @(negedge Clk);
         check("abort_no_done", {31'd0, Done | Busy}, 32'd0);
      end
`else
      Reset_n = 1'b0;
      #1;
      check("mrst_busy",   {31'd0, Busy}, 32'd0);
      check("mrst_done",   {31'd0, Done}, 32'd0);
      check("mrst_result", Result,        32'd0);
      check("mrst_alu_a",  Alu_A,         32'd0);
      for (int c = 0; c < 8; c++) begin
         @(negedge Clk);
         check("mrst_no_done", {31'd0, Done | Busy}, 32'd0);
      end
      Reset_n = 1'b1;
`endif
      @(negedge Clk);
      run_op(4'b0000, 32'd5, 32'd7, 5'd0, 1'b0, busy_n, done_seen);
      check("recover_done",   {31'd0, done_seen}, 32'd1);
      check("recover_busy",   busy_n,             1);
      check("recover_result", Result,             32'd12);

      @(negedge Clk);
      check("done_one_cycle", {31'd0, Done}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
